// File: rtl/eth_rq_pkg.sv
// eth_rq_pkg: shared types and constants for the Ethernet-to-RQ bridge.
package eth_rq_pkg;
  typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, DROP} state_t;
  localparam logic [15:0] ETH_RQ_ETHERTYPE = 16'h88B5;
  localparam int TUSER_W = 60;
  localparam int FIRST_BE_LSB = 0;
  localparam int LAST_BE_LSB = 4;
  localparam int BE_W = 4;
  localparam int ETYPE_BYTE = 4;
  localparam int BE_BYTE = 6;
endpackage

// File: rtl/axis_skid2.sv
// axis_skid2: two-entry registered skid buffer; head entry drives the output directly.
module axis_skid2 #(
  parameter int W = 127
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] d0, d1;
  logic [1:0] cnt;
  logic push, pop;
  assign in_ready = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign out_data = d0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  // a full buffer never accepts, so push and pop together only happen with one entry held
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d0 <= '0;
      d1 <= '0;
      cnt <= '0;
    end else begin
      d0 <= pop ? (cnt == 2'd2 ? d1 : in_data) : (push && cnt == 2'd0 ? in_data : d0);
      d1 <= push && !pop && cnt == 2'd1 ? in_data : d1;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/eth_rq_bridge.sv
// eth_rq_bridge: strips the 16-byte Ethernet encapsulation and replays the TLP on RQ; ETH_RQ_STATS_EN enables counters.
module eth_rq_bridge
  import eth_rq_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = C_DATA_WIDTH / 32,
  parameter logic [15:0] ETHERTYPE = ETH_RQ_ETHERTYPE
) (
  input  logic                      user_clk,
  input  logic                      cold_reset,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_rx_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_rx_tkeep,
  input  logic                      s_axis_rx_tvalid,
  input  logic                      s_axis_rx_tlast,
  output logic                      s_axis_rx_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]     m_axis_rq_tkeep,
  output logic [TUSER_W-1:0]        m_axis_rq_tuser,
  output logic                      m_axis_rq_tlast,
  output logic                      m_axis_rq_tvalid,
  input  logic                      m_axis_rq_tready,
  output logic [15:0]               drop_count,
  output logic [15:0]               runt_count
);
  localparam int SW = C_DATA_WIDTH + KEEP_WIDTH + TUSER_W + 1;
  state_t state, state_d;
  logic accept, match, push, latch_be, skid_ready;
  logic [7:0] be_q;
  logic [KEEP_WIDTH-1:0] dw_keep;
  logic [TUSER_W-1:0] tuser;
  assign accept = s_axis_rx_tvalid & s_axis_rx_tready;
  assign match = {s_axis_rx_tdata[ETYPE_BYTE*8+:8], s_axis_rx_tdata[(ETYPE_BYTE+1)*8+:8]} == ETHERTYPE;
  always_ff @(posedge user_clk or posedge cold_reset)
    if (cold_reset) state <= HDR0;
    else state <= state_d;
  always_comb
    state_d = !accept ? state :
              s_axis_rx_tlast ? HDR0 :
              state == HDR0 ? HDR1 :
              state == HDR1 ? (match ? PAYLOAD : DROP) : state;
  always_comb begin
    s_axis_rx_tready = !cold_reset && (state != PAYLOAD || skid_ready);
    push = accept && state == PAYLOAD;
    latch_be = accept && state == HDR1;
  end
  always_ff @(posedge user_clk or posedge cold_reset)
    if (cold_reset) be_q <= '0;
    else if (latch_be) be_q <= s_axis_rx_tdata[BE_BYTE*8+:8];
  for (genvar k = 0; k < KEEP_WIDTH; k++) begin : g_keep
    assign dw_keep[k] = &s_axis_rx_tkeep[4*k+:4];
  end
  always_comb begin
    tuser = '0;
    tuser[FIRST_BE_LSB+:BE_W] = be_q[3:0];
    tuser[LAST_BE_LSB+:BE_W] = be_q[7:4];
  end
  axis_skid2 #(.W(SW)) u_skid (
    .clk      (user_clk),
    .rst      (cold_reset),
    .in_data  ({s_axis_rx_tdata, dw_keep, tuser, s_axis_rx_tlast}),
    .in_valid (push),
    .in_ready (skid_ready),
    .out_data ({m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tuser, m_axis_rq_tlast}),
    .out_valid(m_axis_rq_tvalid),
    .out_ready(m_axis_rq_tready)
  );
`ifdef ETH_RQ_STATS_EN
  logic drop_inc, runt_inc;
  // a mismatching header is counted as a drop even when it also ends the frame
  assign drop_inc = accept && state == HDR1 && !match;
  assign runt_inc = accept && s_axis_rx_tlast && (state == HDR0 || (state == HDR1 && match));
  always_ff @(posedge user_clk or posedge cold_reset)
    if (cold_reset) begin
      drop_count <= '0;
      runt_count <= '0;
    end else begin
      drop_count <= drop_count + {15'd0, drop_inc && drop_count != 16'hFFFF};
      runt_count <= runt_count + {15'd0, runt_inc && runt_count != 16'hFFFF};
    end
`else
  assign drop_count = '0;
  assign runt_count = '0;
`endif
endmodule

// File: tb/tb_eth_rq_bridge.sv
// tb_eth_rq_bridge: directed frames with a scoreboard of expected RQ beats for eth_rq_bridge.
module tb_eth_rq_bridge;
`ifdef ETH_RQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic user_clk = 1'b0, cold_reset = 1'b1;
  logic [63:0] s_tdata = '0;
  logic [7:0] s_tkeep = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [63:0] m_tdata;
  logic [1:0] m_tkeep;
  logic [59:0] m_tuser;
  logic m_tlast, m_tvalid;
  logic m_tready = 1'b1;
  logic [15:0] drop_count, runt_count;
  int total = 0, bad = 0;
  int exp_drop = 0, exp_runt = 0;
  bit rnd = 1'b0;
  logic [126:0] exp_q[$];
  logic [126:0] obs, held, e;
  bit stall = 1'b0;

  eth_rq_bridge dut (
    .user_clk(user_clk), .cold_reset(cold_reset),
    .s_axis_rx_tdata(s_tdata), .s_axis_rx_tkeep(s_tkeep), .s_axis_rx_tvalid(s_tvalid),
    .s_axis_rx_tlast(s_tlast), .s_axis_rx_tready(s_tready),
    .m_axis_rq_tdata(m_tdata), .m_axis_rq_tkeep(m_tkeep), .m_axis_rq_tuser(m_tuser),
    .m_axis_rq_tlast(m_tlast), .m_axis_rq_tvalid(m_tvalid), .m_axis_rq_tready(m_tready),
    .drop_count(drop_count), .runt_count(runt_count)
  );

  always #5 user_clk = ~user_clk;
  initial forever begin
    @(posedge user_clk);
    #1 m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  assign obs = {m_tdata, m_tkeep, m_tuser, m_tlast};
  always @(negedge user_clk) begin
    if (cold_reset) stall = 1'b0;
    else begin
      if (stall) begin
        total++;
        assert (m_tvalid === 1'b1 && obs === held)
        else begin bad++; $error("FAIL hold obs=%h/%h exp=1/%h", m_tvalid, obs, held); end
      end
      if (m_tvalid && m_tready) begin
        total++;
        assert (exp_q.size() != 0)
        else begin bad++; $error("FAIL unexpected_beat obs=%h exp=none", obs); end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          total++;
          assert (obs === e)
          else begin bad++; $error("FAIL rq_beat obs=%h exp=%h", obs, e); end
        end
      end
      stall = m_tvalid && !m_tready;
      held = obs;
    end
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] x);
    total++;
    assert (o === x)
    else begin bad++; $error("FAIL %s obs=%h exp=%h", tag, o, x); end
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input bit hdr, input bit lat);
    int n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    if (hdr) chk("hdr_tready", 64'(s_tready), 64'd1);
    while (!s_tready && n < 200) begin @(negedge user_clk); n++; end
    if (n == 200) chk("accept_timeout", 64'd0, 64'd1);
    @(negedge user_clk);
    if (lat) chk("latency1", {m_tvalid, m_tdata[62:0]}, {1'b1, d[62:0]});
  endtask

  task automatic frame(input logic [15:0] et, input logic [7:0] be, input int nb, input logic [7:0] lk, input int upto);
    for (int i = 0; i < upto; i++) begin
      logic [63:0] d;
      logic [7:0] k;
      logic l;
      bit fwd;
      l = (i == nb - 1);
      k = l ? lk : 8'hFF;
      d = {$urandom, $urandom};
      if (i == 1) begin d[39:32] = et[15:8]; d[47:40] = et[7:0]; d[55:48] = be; end
      fwd = i >= 2 && et == 16'h88B5;
      if (fwd) exp_q.push_back({d, &k[7:4], &k[3:0], 52'd0, be, l});
      beat(d, k, l, !fwd, fwd && !rnd);
    end
    if (upto == nb) begin
      if (nb >= 2 && et != 16'h88B5) exp_drop++;
      else if (nb <= 2) exp_runt++;
    end
  endtask

  task automatic drain();
    int n = 0;
    s_tvalid = 1'b0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge user_clk); n++; end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge user_clk);
    chk("rq_idle", 64'(m_tvalid), 64'd0);
  endtask

  task automatic counts();
    chk("drop_count", 64'(drop_count), STATS ? 64'(exp_drop) : 64'd0);
    chk("runt_count", 64'(runt_count), STATS ? 64'(exp_runt) : 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge user_clk);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_m_side", {m_tkeep, m_tuser, m_tlast}, 64'd0);
    counts();
    cold_reset = 1'b0;
    @(negedge user_clk);
    chk("idle_s_tready", 64'(s_tready), 64'd1);
    // forwarded frame with latency check
    frame(16'h88B5, 8'hF3, 5, 8'hFF, 5);
    drain();
    // wrong ethertype is dropped
    frame(16'h0800, 8'h00, 5, 8'hFF, 5);
    drain();
    counts();
    // runts then an intact frame
    frame(16'h88B5, 8'h11, 1, 8'hFF, 1);
    frame(16'h88B5, 8'h22, 2, 8'hFF, 2);
    frame(16'h88B5, 8'hA5, 4, 8'hFF, 4);
    drain();
    counts();
    // back-to-back with random RQ backpressure
    rnd = 1'b1;
    for (int f = 0; f < 8; f++)
      frame(f == 5 ? 16'h86DD : 16'h88B5, 8'($urandom), 3 + (f % 6), 8'hFF, 3 + (f % 6));
    drain();
    counts();
    rnd = 1'b0;
    // dword keep on last beat
    frame(16'h88B5, 8'h0F, 3, 8'h0F, 3);
    frame(16'h88B5, 8'hFF, 3, 8'hFF, 3);
    drain();
    counts();
    // reset mid-payload
    frame(16'h88B5, 8'h5A, 6, 8'hFF, 4);
    cold_reset = 1'b1;
    #1;
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    chk("midrst_drop", 64'(drop_count), 64'd0);
    chk("midrst_runt", 64'(runt_count), 64'd0);
    exp_q.delete();
    exp_drop = 0;
    exp_runt = 0;
    s_tvalid = 1'b0;
    @(negedge user_clk);
    cold_reset = 1'b0;
    @(negedge user_clk);
    frame(16'h88B5, 8'h3C, 4, 8'h0F, 4);
    drain();
    counts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
